// File: rtl/line_mem_pkg.sv
// Shared types and geometry for the line transfer responder.
package line_mem_pkg;

  typedef enum logic [1:0] {
    IDLE,
    WAIT,
    XFER,
    DONE
  } state_t;

  typedef enum logic {
    OP_LOAD,
    OP_STORE
  } op_t;

  localparam int WORDS_PER_LINE = 16;
  localparam int BEAT_W         = 4;
  localparam int LINE_OFS_LO    = 6;
  localparam int WAIT_W         = 4;

endpackage

// File: rtl/line_mem_array.sv
// Backing storage: one synchronous write port, one asynchronous read port,
// both addressed by {line, beat}.
module line_mem_array
  import line_mem_pkg::*;
#(
  parameter int LINE_AW = 6
) (
  input  logic               clk,
  input  logic               we,
  input  logic [LINE_AW-1:0] line,
  input  logic [BEAT_W-1:0]  beat,
  input  logic [31:0]        wdata,
  output logic [31:0]        rdata
);

  localparam int DEPTH = WORDS_PER_LINE << LINE_AW;

  logic [31:0] mem [DEPTH];

  // NOTE: storage has no reset; a reset would turn the array into flops and
  // words written before an aborted transaction must survive anyway.
  always_ff @(posedge clk) begin
    if (we) begin
      mem[{line, beat}] <= wdata;
    end
  end

  assign rdata = mem[{line, beat}];

endmodule

// File: rtl/line_mem_responder.sv
// Memory-side end of the cache line transfer handshake: streams 16-word
// fills and absorbs 16-word write-backs, ending each with a complete pulse.
module line_mem_responder
  import line_mem_pkg::*;
#(
  parameter int LATENCY = 4,
  parameter int LINE_AW = 6
) (
  input  logic              clk,
  input  logic              rst,
  input  logic              load,
  input  logic              store,
  input  logic [31:0]       addr_in,
  input  logic [31:0]       store_data,
  output logic [31:0]       load_data,
  output logic              data_valid,
  output logic [BEAT_W-1:0] beat,
  output logic              busy,
  output logic              complete
);

  state_t             state;
  op_t                op;
  logic [LINE_AW-1:0] line;
  logic [WAIT_W-1:0]  wait_cnt;
  logic [BEAT_W-1:0]  beat_cnt;
  logic [31:0]        rd_word;
  logic               unused_addr;

  // Only the line-select field of the address matters; the rest aliases.
  assign unused_addr = ^{addr_in[31:LINE_OFS_LO+LINE_AW], addr_in[LINE_OFS_LO-1:0]};

  // NOTE: sequential state uses non-blocking assignments so every register
  // samples pre-edge values regardless of statement order.
  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      state      <= IDLE;
      op         <= OP_LOAD;
      line       <= '0;
      wait_cnt   <= '0;
      beat_cnt   <= '0;
      data_valid <= 1'b0;
      busy       <= 1'b0;
      complete   <= 1'b0;
    end else begin
      case (state)
        IDLE: begin
          if (load || store) begin
            op       <= store ? OP_STORE : OP_LOAD;
            line     <= addr_in[LINE_OFS_LO +: LINE_AW];
            wait_cnt <= WAIT_W'(LATENCY - 1);
            busy     <= 1'b1;
            state    <= WAIT;
          end
        end
        WAIT: begin
          if (wait_cnt == '0) begin
            data_valid <= 1'b1;
            state      <= XFER;
          end else begin
            wait_cnt <= wait_cnt - WAIT_W'(1);
          end
        end
        XFER: begin
          // The beat counter wraps to 0 on the last beat, ready for the next line.
          beat_cnt <= beat_cnt + BEAT_W'(1);
          if (beat_cnt == BEAT_W'(WORDS_PER_LINE - 1)) begin
            data_valid <= 1'b0;
            complete   <= 1'b1;
            state      <= DONE;
          end
        end
        DONE: begin
          complete <= 1'b0;
          busy     <= 1'b0;
          state    <= IDLE;
        end
        default: state <= IDLE;
      endcase
    end
  end

  line_mem_array #(
    .LINE_AW(LINE_AW)
  ) u_array (
    .clk  (clk),
    .we   ((state == XFER) && (op == OP_STORE)),
    .line (line),
    .beat (beat_cnt),
    .wdata(store_data),
    .rdata(rd_word)
  );

  assign beat      = beat_cnt;
  assign load_data = (state == XFER) ? rd_word : 32'h0;

endmodule

// File: doc/line_mem_responder.md
# line_mem_responder

- Memory-side responder for the set-associative cache controller's line transfer port.
- Serves line fills (`load`) by streaming 16 words from backing storage.
- Absorbs write-backs (`store`) by capturing 16 words of `store_data` into backing storage.
- Signals end of every transaction with a one-cycle `complete` pulse.
- Sits between the cache controller and a behavioural/synthesizable main-memory array; it is the far end of the `load`/`store`/`complete` handshake.

## Interface
- `LATENCY`, 4: cycles from request acceptance to first beat; legal range 1..15.
- `LINE_AW`, 6: line-address width; storage holds 2^LINE_AW lines × 16 words.
- `clk`  in  1  system clock, all state on rising edge.
- `rst`  in  1  reset; one clock domain; asynchronous, active-low.
- `load`  in  1  line-fill request (memory → cache); level, held until `complete`.
- `store`  in  1  write-back request (cache → memory); level, held until `complete`.
- `addr_in`  in  32  line address; bits [LINE_AW+5:6] select the line; all other bits ignored.
- `store_data`  in  32  write-back word for the current `beat`.
- `load_data`  out  32  fill word for the current `beat`; valid only while `data_valid`.
- `data_valid`  out  1  beat strobe; high for exactly 16 consecutive cycles per transaction.
- `beat`  out  4  word index within line, 0..15.
- `busy`  out  1  high from request acceptance through the `complete` cycle.
- `complete`  out  1  one-cycle pulse ending the transaction.

## Operation
- States: IDLE, WAIT, XFER, DONE.
- IDLE:
  - `load` or `store` high at a rising edge: latch op and line index, load wait counter with LATENCY-1, go to WAIT.
  - Both high: `store` wins and `load` is ignored. The cache must re-present `load` after `complete`.
- WAIT: decrement wait counter; go to XFER at the edge where counter = 0.
- XFER:
  - `data_valid`=1, `beat`=beat counter (starts at 0).
  - Store op: `mem[line][beat] <= store_data` at each edge.
  - Load op: `load_data = mem[line][beat]`, combinational array read.
  - At beat 15, go to DONE; beat counter wraps to 0.
- DONE: `complete`=1 for one cycle, then go to IDLE.
- Request inputs are sampled only in IDLE. `load`/`store`/`addr_in` changes during WAIT/XFER/DONE are ignored.
- Line index uses the latched copy of `addr_in`, not the live input.
- Address aliasing: lines differing only above bit LINE_AW+5 map to the same storage.
- `load_data` outside XFER: drive 0.
- Storage is not reset; contents before the first write are undefined.

## Timing
- Reset (asserted or mid-transaction):
  - State goes to IDLE.
  - `data_valid`, `busy`, `complete` = 0; `beat`, `load_data` = 0; wait and beat counters = 0.
  - Words already written by an aborted store persist.
- Request accepted at edge E0:
  - `busy` high after E0.
  - `data_valid` high after edges E0+LATENCY … E0+LATENCY+15.
  - `complete` high after edge E0+LATENCY+16.
  - IDLE after E0+LATENCY+17.
- Transaction length: LATENCY+17 cycles.
- Back-to-back: a request still high in the IDLE cycle after DONE is accepted immediately. The cache must drop its request at the edge ending `complete`.
- All control outputs are registered or decoded from state (Moore). `load_data` is combinational from the beat counter and the latched line.

## Structure
- Package `line_mem_pkg`:
  - State enum.
  - `WORDS_PER_LINE`=16, `BEAT_W`=4.
  - `LINE_OFS_LO`=6 (line-address LSB).
- Sub-module `line_mem_array`:
  - 2^LINE_AW×16×32 storage.
  - One synchronous write port and one asynchronous read port.
  - Address = {line, beat}.
- Top holds the FSM, counters, and request latch.

## Test plan
- Reset: drive `rst`=0 mid-XFER (beat 7) → next cycle all outputs 0 and state IDLE; the first 7 words of the aborted store are readable by a later load.
- Write-back then fill, LATENCY=4:
  - `store`, `addr_in`=0x0000_0140 (line 5), `store_data`=0xA000_0000+beat.
  - Then `load` to the same line → `load_data`=0xA000_0000..0xA000_000F on beats 0..15.
  - `complete` exactly 20 cycles after each acceptance edge.
- Simultaneous request: `load`=`store`=1 in IDLE → store executes (`store_data` captured); after `complete`, the held `load` is accepted in the following IDLE cycle.
- Aliasing: store 0xDEAD_0000+beat to `addr_in`=0x0000_1140, then load `addr_in`=0x0000_0140 → returns 0xDEAD_0000..0xDEAD_000F.
- Request change mid-transaction: switch `addr_in` to line 9 during WAIT → transfer still uses line 5; `data_valid` stays high for exactly 16 cycles.
- LATENCY=1 build: first `data_valid` one cycle after acceptance; `complete` at E0+17.
